execution_controller: RTL and testbench

Run/halt/single-step sequencer for the single-cycle JZJCoreF datapath. Produces one `coreEnable` strobe that gates program-counter writes, register-file writes and memory/MMIO writes, so each enabled cycle retires exactly one instruction. It stops the core on an external halt request, on a PC breakpoint, or on a datapath error flag, and keeps cycle and retired-instruction counters for debug and MMIO exposure.

---
 rtl/execution_controller_if.sv | 29 ++
 rtl/execution_controller.sv | 110 +++++++++++
 tb/tb_execution_controller.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execution_controller_if.sv
// Debug/control bundle between the execution controller and its requester (debug unit or MMIO block).
// Requests are single-cycle pulses with no handshake; status and counters are level outputs.
interface execution_controller_if;
  logic        runRequest;
  logic        haltRequest;
  logic        stepRequest;
  logic        breakpointEnable;
  logic [31:0] breakpointAddress;
  logic [31:0] pcOfInstruction;
  logic        instructionFault;
  logic        counterClear;
  logic        coreEnable;
  logic        halted;
  logic [1:0]  haltCause;
  logic [31:0] cycleCount;
  logic [31:0] retiredCount;

  modport master (
    output runRequest, haltRequest, stepRequest, breakpointEnable, breakpointAddress,
           pcOfInstruction, instructionFault, counterClear,
    input  coreEnable, halted, haltCause, cycleCount, retiredCount
  );

  modport slave (
    input  runRequest, haltRequest, stepRequest, breakpointEnable, breakpointAddress,
           pcOfInstruction, instructionFault, counterClear,
    output coreEnable, halted, haltCause, cycleCount, retiredCount
  );
endinterface

// File: rtl/execution_controller.sv
// Run/halt/single-step sequencer; coreEnable is zero-latency combinational, status and counters registered.
// No backpressure: requests are one-cycle pulses, ignored in states where they have no meaning.
module execution_controller #(
  parameter bit START_RUNNING = 1'b1
) (
  input logic                   clock,
  input logic                   reset,
  execution_controller_if.slave ctl
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_RESET = 2'd0;
  localparam logic [1:0] CAUSE_REQ   = 2'd1;
  localparam logic [1:0] CAUSE_BP    = 2'd2;
  localparam logic [1:0] CAUSE_FAULT = 2'd3;

  localparam state_t RESET_STATE = START_RUNNING ? ST_RUN : ST_HALTED;

  state_t      state_q, state_d;
  logic        halted_q, halted_d;
  logic [1:0]  cause_q, cause_d;
  logic        skip_bp_q, skip_bp_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] retired_count_q, retired_count_d;
  logic        bp_hit;
  logic        core_en;

  always_comb begin
    bp_hit    = ctl.breakpointEnable && (ctl.pcOfInstruction == ctl.breakpointAddress) && !skip_bp_q;
    state_d   = state_q;
    cause_d   = cause_q;
    skip_bp_d = skip_bp_q;
    core_en   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (ctl.instructionFault) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_FAULT;
        end else if (bp_hit) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
        end else if (ctl.haltRequest) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_REQ;
        end else begin
          core_en   = 1'b1;
          skip_bp_d = 1'b0;
        end
      end
      ST_HALTED: begin
        if (ctl.stepRequest || ctl.runRequest) begin
          state_d = ctl.stepRequest ? ST_STEP : ST_RUN;
          // Resuming from a breakpoint must let that very instruction retire once.
          if (cause_q == CAUSE_BP) begin
            skip_bp_d = 1'b1;
          end
        end
      end
      ST_STEP: begin
        state_d = ST_HALTED;
        if (ctl.instructionFault) begin
          cause_d = CAUSE_FAULT;
        end else begin
          core_en   = 1'b1;
          cause_d   = CAUSE_REQ;
          skip_bp_d = 1'b0;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase

    halted_d        = (state_d == ST_HALTED);
    cycle_count_d   = ctl.counterClear ? 32'd0 : cycle_count_q + 32'd1;
    retired_count_d = ctl.counterClear ? 32'd0 : retired_count_q + {31'd0, core_en};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= RESET_STATE;
      halted_q        <= !START_RUNNING;
      cause_q         <= CAUSE_RESET;
      skip_bp_q       <= 1'b0;
      cycle_count_q   <= 32'd0;
      retired_count_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      halted_q        <= halted_d;
      cause_q         <= cause_d;
      skip_bp_q       <= skip_bp_d;
      cycle_count_q   <= cycle_count_d;
      retired_count_q <= retired_count_d;
    end
  end

  // Gate with reset so nothing commits while the async reset is asserted.
  assign ctl.coreEnable   = core_en & reset;
  assign ctl.halted       = halted_q;
  assign ctl.haltCause    = cause_q;
  assign ctl.cycleCount   = cycle_count_q;
  assign ctl.retiredCount = retired_count_q;

endmodule

// File: tb/tb_execution_controller.sv
// Bench for execution_controller: directed scenarios plus randomized traffic against a rule-level model.
module tb_execution_controller;
  logic clock = 1'b0;
  logic reset;

  execution_controller_if ctl();

  execution_controller #(.START_RUNNING(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .ctl   (ctl)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: "what the core is doing" in plain terms.
  bit          m_halted;
  bit          m_stepping;
  bit          m_skip;
  logic [1:0]  m_cause;
  logic [31:0] m_cyc;
  logic [31:0] m_ret;
  bit          auto_pc = 1'b0;

  task automatic model_reset();
    m_halted   = 1'b0;
    m_stepping = 1'b0;
    m_skip     = 1'b0;
    m_cause    = 2'd0;
    m_cyc      = 32'd0;
    m_ret      = 32'd0;
  endtask

  function automatic bit model_enable();
    bit bp;
    if (reset !== 1'b1) return 1'b0;
    bp = ctl.breakpointEnable && (ctl.pcOfInstruction == ctl.breakpointAddress) && !m_skip;
    if (m_stepping) return !ctl.instructionFault;
    if (m_halted) return 1'b0;
    return !(ctl.instructionFault || bp || ctl.haltRequest);
  endfunction

  task automatic idle_inputs();
    ctl.runRequest       = 1'b0;
    ctl.haltRequest      = 1'b0;
    ctl.stepRequest      = 1'b0;
    ctl.instructionFault = 1'b0;
    ctl.counterClear     = 1'b0;
  endtask

  // Advance one clock (negedge to negedge) and apply the rules to the model.
  task automatic tick();
    bit en, bp, f, h, r, s, c;
    en = model_enable();
    f  = ctl.instructionFault;
    h  = ctl.haltRequest;
    r  = ctl.runRequest;
    s  = ctl.stepRequest;
    c  = ctl.counterClear;
    bp = ctl.breakpointEnable && (ctl.pcOfInstruction == ctl.breakpointAddress) && !m_skip;
    @(posedge clock);
    m_cyc = c ? 32'd0 : m_cyc + 32'd1;
    m_ret = c ? 32'd0 : m_ret + {31'd0, en};
    if (m_stepping) begin
      m_stepping = 1'b0;
      m_halted   = 1'b1;
      m_cause    = f ? 2'd3 : 2'd1;
      if (!f) m_skip = 1'b0;
    end else if (m_halted) begin
      if (s || r) begin
        m_halted   = 1'b0;
        m_stepping = s;
        if (m_cause == 2'd2) m_skip = 1'b1;
      end
    end else if (f) begin
      m_halted = 1'b1;
      m_cause  = 2'd3;
    end else if (bp) begin
      m_halted = 1'b1;
      m_cause  = 2'd2;
    end else if (h) begin
      m_halted = 1'b1;
      m_cause  = 2'd1;
    end else begin
      m_skip = 1'b0;
    end
    @(negedge clock);
    if (auto_pc && en) ctl.pcOfInstruction = (ctl.pcOfInstruction + 32'd4) & 32'h1F;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    ctl.breakpointEnable  = 1'b0;
    ctl.breakpointAddress = 32'h0;
    ctl.pcOfInstruction   = 32'h100;
    model_reset();
    repeat (2) @(negedge clock);
    n_tests++; if (ctl.coreEnable !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", ctl.coreEnable); end
    n_tests++; if (ctl.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", ctl.halted); end
    n_tests++; if (ctl.haltCause !== 2'd0) begin n_fail++; $display("FAIL reset_cause: got %0d want 0", ctl.haltCause); end
    n_tests++; if (ctl.cycleCount !== 32'd0) begin n_fail++; $display("FAIL reset_cycle: got %0h want 0", ctl.cycleCount); end
    n_tests++; if (ctl.retiredCount !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %0h want 0", ctl.retiredCount); end
    reset = 1'b1;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 10; i++) begin
      #1;
      n_tests++; if (ctl.coreEnable !== 1'b1) begin n_fail++; $display("FAIL run_en[%0d]: got %b want 1", i, ctl.coreEnable); end
      tick();
    end
    #1;
    n_tests++; if (ctl.retiredCount !== 32'd10) begin n_fail++; $display("FAIL run_retired: got %0d want 10", ctl.retiredCount); end
    n_tests++; if (ctl.cycleCount !== 32'd10) begin n_fail++; $display("FAIL run_cycle: got %0d want 10", ctl.cycleCount); end
    n_tests++; if (ctl.halted !== 1'b0) begin n_fail++; $display("FAIL run_halted: got %b want 0", ctl.halted); end
    n_tests++; if (ctl.haltCause !== 2'd0) begin n_fail++; $display("FAIL run_cause: got %0d want 0", ctl.haltCause); end
  endtask

  task automatic test_breakpoint();
    bit found;
    ctl.pcOfInstruction   = 32'h0;
    ctl.breakpointAddress = 32'h10;
    ctl.breakpointEnable  = 1'b1;
    auto_pc = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
        #1;
        if (ctl.pcOfInstruction == 32'h10) begin
          found = 1'b1;
          n_tests++; if (ctl.coreEnable !== 1'b0) begin n_fail++; $display("FAIL bp_suppress[%0d]: got %b want 0", pass, ctl.coreEnable); end
        end else begin
          n_tests++; if (ctl.coreEnable !== 1'b1) begin n_fail++; $display("FAIL bp_approach[%0d]: got %b want 1", pass, ctl.coreEnable); end
        end
        tick();
      end
      if (!found) begin
        n_tests++; n_fail++; $display("FAIL bp_reach[%0d]: pc never reached 0x10, pc=%0h", pass, ctl.pcOfInstruction);
      end
      #1;
      n_tests++; if (ctl.halted !== 1'b1) begin n_fail++; $display("FAIL bp_halted[%0d]: got %b want 1", pass, ctl.halted); end
      n_tests++; if (ctl.haltCause !== 2'd2) begin n_fail++; $display("FAIL bp_cause[%0d]: got %0d want 2", pass, ctl.haltCause); end
      if (pass == 0) begin
        ctl.haltRequest = 1'b1;
        #1;
        n_tests++; if (ctl.coreEnable !== 1'b0) begin n_fail++; $display("FAIL bp_idle_en: got %b want 0", ctl.coreEnable); end
        tick();
        ctl.haltRequest = 1'b0;
        ctl.runRequest  = 1'b1;
        #1;
        n_tests++; if (ctl.coreEnable !== 1'b0) begin n_fail++; $display("FAIL bp_run_req_en: got %b want 0", ctl.coreEnable); end
        tick();
        ctl.runRequest = 1'b0;
        #1;
        n_tests++; if (ctl.coreEnable !== 1'b1 || ctl.pcOfInstruction !== 32'h10) begin
          n_fail++; $display("FAIL bp_resume_commit: got en=%b pc=%0h want en=1 pc=10", ctl.coreEnable, ctl.pcOfInstruction);
        end
        n_tests++; if (ctl.halted !== 1'b0) begin n_fail++; $display("FAIL bp_resume_halted: got %b want 0", ctl.halted); end
        tick();
      end
    end
    auto_pc = 1'b0;
  endtask

  task automatic test_fault_halt();
    logic [31:0] ret0;
    ctl.breakpointEnable = 1'b0;
    ctl.pcOfInstruction  = 32'h200;
    ctl.runRequest = 1'b1;
    tick();
    ctl.runRequest       = 1'b0;
    ctl.haltRequest      = 1'b1;
    ctl.instructionFault = 1'b1;
    ret0 = m_ret;
    #1;
    n_tests++; if (ctl.coreEnable !== 1'b0) begin n_fail++; $display("FAIL fault_en: got %b want 0", ctl.coreEnable); end
    tick();
    idle_inputs();
    #1;
    n_tests++; if (ctl.halted !== 1'b1) begin n_fail++; $display("FAIL fault_halted: got %b want 1", ctl.halted); end
    n_tests++; if (ctl.haltCause !== 2'd3) begin n_fail++; $display("FAIL fault_cause: got %0d want 3", ctl.haltCause); end
    n_tests++; if (ctl.retiredCount !== ret0) begin n_fail++; $display("FAIL fault_retired: got %0d want %0d", ctl.retiredCount, ret0); end
    for (int k = 0; k < 3; k++) begin
      ctl.stepRequest = 1'b1;
      ctl.runRequest  = (k == 0);
      #1;
      n_tests++; if (ctl.coreEnable !== 1'b0) begin n_fail++; $display("FAIL step_req_en[%0d]: got %b want 0", k, ctl.coreEnable); end
      tick();
      idle_inputs();
      #1;
      n_tests++; if (ctl.coreEnable !== 1'b1 || ctl.halted !== 1'b0) begin
        n_fail++; $display("FAIL step_exec[%0d]: got en=%b halted=%b want en=1 halted=0", k, ctl.coreEnable, ctl.halted);
      end
      tick();
      #1;
      n_tests++; if (ctl.halted !== 1'b1 || ctl.haltCause !== 2'd1) begin
        n_fail++; $display("FAIL step_after[%0d]: got halted=%b cause=%0d want halted=1 cause=1", k, ctl.halted, ctl.haltCause);
      end
    end
    n_tests++; if (ctl.retiredCount !== ret0 + 32'd3) begin n_fail++; $display("FAIL step_retired: got %0d want %0d", ctl.retiredCount, ret0 + 32'd3); end
  endtask

  task automatic test_wrap();
    ctl.runRequest = 1'b1;
    tick();
    ctl.runRequest = 1'b0;
    force dut.retired_count_q = 32'hFFFF_FFFF;
    force dut.cycle_count_q   = 32'hFFFF_FFFF;
    m_ret = 32'hFFFF_FFFF;
    m_cyc = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count_q;
    release dut.cycle_count_q;
    #1;
    n_tests++; if (ctl.coreEnable !== 1'b1) begin n_fail++; $display("FAIL wrap_en: got %b want 1", ctl.coreEnable); end
    tick();
    #1;
    n_tests++; if (ctl.retiredCount !== 32'd0) begin n_fail++; $display("FAIL wrap_retired: got %0h want 0", ctl.retiredCount); end
    n_tests++; if (ctl.cycleCount !== 32'd0) begin n_fail++; $display("FAIL wrap_cycle: got %0h want 0", ctl.cycleCount); end
    ctl.counterClear = 1'b1;
    #1;
    n_tests++; if (ctl.coreEnable !== 1'b1) begin n_fail++; $display("FAIL clear_en: got %b want 1", ctl.coreEnable); end
    tick();
    ctl.counterClear = 1'b0;
    #1;
    n_tests++; if (ctl.retiredCount !== 32'd0) begin n_fail++; $display("FAIL clear_retired: got %0h want 0", ctl.retiredCount); end
    n_tests++; if (ctl.cycleCount !== 32'd0) begin n_fail++; $display("FAIL clear_cycle: got %0h want 0", ctl.cycleCount); end
  endtask

  task automatic test_random();
    bit hold_step = 1'b0;
    ctl.breakpointAddress = 32'h8;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) hold_step = ($urandom_range(0, 3) == 0);
      ctl.pcOfInstruction  = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      ctl.breakpointEnable = ($urandom_range(0, 3) != 0);
      ctl.runRequest       = ($urandom_range(0, 7) == 0);
      ctl.haltRequest      = ($urandom_range(0, 9) == 0);
      ctl.stepRequest      = hold_step || ($urandom_range(0, 7) == 0);
      ctl.instructionFault = ($urandom_range(0, 15) == 0);
      ctl.counterClear     = ($urandom_range(0, 63) == 0);
      #1;
      n_tests++; if (ctl.coreEnable !== model_enable()) begin n_fail++; $display("FAIL rnd_en[%0d]: got %b want %b", i, ctl.coreEnable, model_enable()); end
      tick();
      #1;
      n_tests++; if (ctl.halted !== m_halted || ctl.haltCause !== m_cause) begin
        n_fail++; $display("FAIL rnd_state[%0d]: got halted=%b cause=%0d want halted=%b cause=%0d", i, ctl.halted, ctl.haltCause, m_halted, m_cause);
      end
      n_tests++; if (ctl.cycleCount !== m_cyc || ctl.retiredCount !== m_ret) begin
        n_fail++; $display("FAIL rnd_count[%0d]: got cyc=%0d ret=%0d want cyc=%0d ret=%0d", i, ctl.cycleCount, ctl.retiredCount, m_cyc, m_ret);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_step();
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    ctl.pcOfInstruction   = 32'h40;
    ctl.breakpointAddress = 32'h40;
    ctl.breakpointEnable  = 1'b1;
    #1;
    n_tests++; if (ctl.coreEnable !== 1'b0) begin n_fail++; $display("FAIL mid_bp_en: got %b want 0", ctl.coreEnable); end
    tick();
    ctl.stepRequest = 1'b1;
    tick();
    ctl.stepRequest = 1'b0;
    #1;
    n_tests++; if (ctl.coreEnable !== 1'b1) begin n_fail++; $display("FAIL mid_step_en: got %b want 1", ctl.coreEnable); end
    reset = 1'b0;
    model_reset();
    #1;
    n_tests++; if (ctl.coreEnable !== 1'b0) begin n_fail++; $display("FAIL mid_reset_en: got %b want 0", ctl.coreEnable); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_tests++; if (ctl.halted !== 1'b0 || ctl.haltCause !== 2'd0) begin
      n_fail++; $display("FAIL mid_reset_state: got halted=%b cause=%0d want 0/0", ctl.halted, ctl.haltCause);
    end
    n_tests++; if (ctl.cycleCount !== 32'd0 || ctl.retiredCount !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset_counts: got cyc=%0d ret=%0d want 0/0", ctl.cycleCount, ctl.retiredCount);
    end
    // With the skip flag cleared the breakpoint must fire again straight out of reset.
    n_tests++; if (ctl.coreEnable !== 1'b0) begin n_fail++; $display("FAIL mid_reset_skip: got %b want 0", ctl.coreEnable); end
    tick();
    #1;
    n_tests++; if (ctl.halted !== 1'b1 || ctl.haltCause !== 2'd2) begin
      n_fail++; $display("FAIL mid_reset_rehalt: got halted=%b cause=%0d want 1/2", ctl.halted, ctl.haltCause);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_free_run();
    test_breakpoint();
    test_fault_halt();
    test_wrap();
    test_random();
    test_reset_mid_step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
